compress_frontend: RTL



---
 rtl/compress_frontend_if.sv | 18 +
 rtl/compress_frontend.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_frontend_if.sv
// compress_frontend_if: 256-bit AXI-Stream bundle used on both sides of the
// compression frontend.
//   tdata  [255:0]  beat payload
//   tkeep  [31:0]   byte enables
//   tvalid          beat valid (source)
//   tlast           last beat of packet (source)
//   tready          sink ready
// master drives tdata/tkeep/tvalid/tlast; slave drives tready.
interface compress_frontend_if;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/compress_frontend.sv
// compress_frontend: transmit-side payload compressor.
// Eligible TCP frames (1514 B, ToS 0x00) keep their header beats (ToS rewritten
// to 0x28); payload beats become a 16-bit code bitmap plus packed words, the
// final beat is appended raw. Other packets pass through unchanged.
//   aclk, areset    clock, asynchronous active-high reset
//   s_axis (slave)  host DMA read stream
//   m_axis (master) MAC transmit stream
//   compressed_pkt  high while a compressed packet is on m_axis
module compress_frontend #(
    parameter int unsigned HDR_BEATS = 4,
    parameter int unsigned PKT_BEATS = 48
) (
    input  logic                aclk,
    input  logic                areset,
    compress_frontend_if.slave  s_axis,
    compress_frontend_if.master m_axis,
    output logic                compressed_pkt
);
    localparam int unsigned CntW = $clog2(PKT_BEATS + 1);

    typedef enum logic [2:0] {StIdle, StBypass, StHeader, StCompress, StTail, StFlush} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            rdy_en_q;
    logic            enc_valid_q;
    logic [271:0]    enc_bits_q;
    logic [8:0]      enc_len_q;
    logic [543:0]    acc_q;
    logic [9:0]      fill_q;
    logic [255:0]    out_data_q;
    logic [31:0]     out_keep_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            comp_q;

    logic [7:0]   tos;
    logic [7:0]   proto;
    logic [15:0]  frame_len;
    logic         eligible;
    logic [255:0] pass_data;
    logic         slot_free;
    logic         pass_path;
    logic         comp_path;
    logic         emit_full;
    logic         emit_final;
    logic         flush_last;
    logic         s_ready;
    logic         accept;
    logic [543:0] base_acc;
    logic [9:0]   base_fill;
    logic [9:0]   fill_next;
    logic [543:0] acc_next;
    logic [271:0] enc_bits;
    logic [8:0]   enc_len;
    logic [271:0] raw_bits;
    logic [8:0]   raw_len;
    logic [5:0]   final_bytes;
    logic [31:0]  final_keep;

    // Beat-0 decode and ToS rewrite for eligible frames.
    always_comb begin
        tos       = s_axis.tdata[127:120];
        proto     = s_axis.tdata[191:184];
        frame_len = {s_axis.tdata[135:128], s_axis.tdata[143:136]} + 16'd14;
        eligible  = (proto == 8'h06) && (tos == 8'h00) && (frame_len == 16'd1514);
        pass_data = s_axis.tdata;
        if (state_q == StIdle && eligible) begin
            pass_data[127:120] = 8'h28;
        end
    end

    // Word encoder: bitmap in [15:0], then payloads packed LSB-first.
    always_comb begin
        int unsigned pos;
        int unsigned n;
        logic [31:0] w;
        logic [31:0] p;
        logic [1:0]  code;
        enc_bits = '0;
        pos      = 16;
        for (int i = 0; i < 8; i++) begin
            w = s_axis.tdata[32*i +: 32];
            if (w == 32'd0) begin
                code = 2'b00; n = 0;  p = 32'd0;
            end else if (w == {{24{w[7]}}, w[7:0]}) begin
                code = 2'b01; n = 8;  p = {24'd0, w[7:0]};
            end else if (w == {{16{w[15]}}, w[15:0]}) begin
                code = 2'b10; n = 16; p = {16'd0, w[15:0]};
            end else begin
                code = 2'b11; n = 32; p = w;
            end
            enc_bits[2*i +: 2] = code;
            enc_bits           = enc_bits | (272'(p) << pos);
            pos                = pos + n;
        end
        enc_len = 9'(pos);
    end

    // Tail beat: kept bytes appended raw, packed densely.
    always_comb begin
        int unsigned rpos;
        raw_bits = '0;
        rpos     = 0;
        for (int b = 0; b < 32; b++) begin
            if (s_axis.tkeep[b]) begin
                raw_bits = raw_bits | (272'(s_axis.tdata[8*b +: 8]) << rpos);
                rpos     = rpos + 8;
            end
        end
        raw_len = 9'(rpos);
    end

    // Accumulator: emit (full or final) and append may share a cycle.
    always_comb begin
        slot_free  = !out_valid_q || m_axis.tready;
        pass_path  = (state_q == StIdle) || (state_q == StBypass) || (state_q == StHeader);
        comp_path  = (state_q == StCompress) || (state_q == StTail);
        emit_full  = (fill_q >= 10'd256) && slot_free;
        emit_final = (state_q == StFlush) && !enc_valid_q && (fill_q != 10'd0)
                     && (fill_q < 10'd256) && slot_free;
        // Final full beat: nothing left in flight and fill drains to exactly zero.
        flush_last = (state_q == StFlush) && !enc_valid_q && (fill_q == 10'd256);
        if (emit_full) begin
            base_acc  = acc_q >> 256;
            base_fill = fill_q - 10'd256;
        end else if (emit_final) begin
            base_acc  = '0;
            base_fill = '0;
        end else begin
            base_acc  = acc_q;
            base_fill = fill_q;
        end
        fill_next = base_fill + (enc_valid_q ? 10'(enc_len_q) : 10'd0);
        acc_next  = base_acc | (enc_valid_q ? ({272'd0, enc_bits_q} << base_fill) : 544'd0);
        // A newly accepted beat appends one cycle later: leave room for 272 bits.
        s_ready = rdy_en_q && slot_free && (pass_path || (comp_path && fill_next <= 10'd271));
        accept  = s_axis.tvalid && s_ready;
        final_bytes = 6'((fill_q + 10'd7) >> 3);
        for (int b = 0; b < 32; b++) begin
            final_keep[b] = (6'(b) < final_bytes);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rdy_en_q    <= 1'b0;
            enc_valid_q <= 1'b0;
            enc_bits_q  <= '0;
            enc_len_q   <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            comp_q      <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            acc_q    <= acc_next;
            fill_q   <= fill_next;

            if (accept && pass_path) begin
                out_data_q  <= pass_data;
                out_keep_q  <= s_axis.tkeep;
                out_last_q  <= s_axis.tlast;
                out_valid_q <= 1'b1;
            end else if (emit_full) begin
                out_data_q  <= acc_q[255:0];
                out_keep_q  <= '1;
                out_last_q  <= flush_last;
                out_valid_q <= 1'b1;
            end else if (emit_final) begin
                out_data_q  <= acc_q[255:0];
                out_keep_q  <= final_keep;
                out_last_q  <= 1'b1;
                out_valid_q <= 1'b1;
            end else if (m_axis.tready) begin
                out_valid_q <= 1'b0;
            end

            if (accept && state_q == StIdle && eligible) begin
                comp_q <= 1'b1;
            end else if (out_valid_q && m_axis.tready && out_last_q) begin
                comp_q <= 1'b0;
            end

            enc_valid_q <= 1'b0;
            if (accept && comp_path) begin
                enc_valid_q <= 1'b1;
                if (state_q == StTail || s_axis.tlast) begin
                    enc_bits_q <= raw_bits;
                    enc_len_q  <= raw_len;
                end else begin
                    enc_bits_q <= enc_bits;
                    enc_len_q  <= enc_len;
                end
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_q <= CntW'(1);
                        if (s_axis.tlast) begin
                            state_q <= StIdle;
                        end else if (eligible) begin
                            state_q <= StHeader;
                        end else begin
                            state_q <= StBypass;
                        end
                    end
                end
                StBypass: begin
                    if (accept && s_axis.tlast) begin
                        state_q <= StIdle;
                    end
                end
                StHeader: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (s_axis.tlast) begin
                            state_q <= StIdle;
                        end else if (cnt_q == CntW'(HDR_BEATS - 1)) begin
                            state_q <= StCompress;
                        end
                    end
                end
                StCompress: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (s_axis.tlast) begin
                            state_q <= StFlush;
                        end else if (cnt_q == CntW'(PKT_BEATS - 2)) begin
                            state_q <= StTail;
                        end
                    end
                end
                StTail: begin
                    if (accept) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if ((emit_full && flush_last) || emit_final
                        || (!enc_valid_q && fill_q == 10'd0)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_axis.tready  = s_ready;
    assign m_axis.tdata   = out_data_q;
    assign m_axis.tkeep   = out_keep_q;
    assign m_axis.tvalid  = out_valid_q;
    assign m_axis.tlast   = out_last_q;
    assign compressed_pkt = comp_q;
endmodule
